// File: rtl/perf_monitor.sv
// Multi-channel event counter bank with a capture register and a registered display port that
// shows one channel at a time, either chosen manually or stepped by a free-running scroll divider.
module perf_monitor #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned N_EVT      = 3,
  parameter int unsigned SATURATE   = 0,
  parameter int unsigned SCROLL_DIV = 50000000,
  localparam int unsigned SEL_W     = ($clog2(N_EVT + 1) > 1) ? $clog2(N_EVT + 1) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             capture,
  input  logic [N_EVT-1:0] evt,
  input  logic             clear,
  input  logic             freeze,
  input  logic [SEL_W-1:0] select,
  input  logic             auto_scroll,
  output logic [WIDTH-1:0] data_out,
  output logic [SEL_W-1:0] sel_out,
  output logic [N_EVT-1:0] ovf
);

  localparam int unsigned DIV_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [DIV_W-1:0] DivLast = DIV_W'(SCROLL_DIV - 1);
  localparam logic [SEL_W-1:0] IdxLast = SEL_W'(N_EVT);

  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] cnt_q [N_EVT];
  logic [WIDTH-1:0] cnt_d [N_EVT];
  logic [N_EVT-1:0] ovf_q, ovf_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [SEL_W-1:0] sel_out_q, sel_out_d;
  logic [WIDTH-1:0] chan_val;

  // Capture register ignores clear and freeze; it is a user scratch value, not a counter.
  always_comb begin
    cap_d = cap_q;
    if (capture) begin
      cap_d = data_in;
    end
  end

  // Counter next-state: clear wins over freeze, freeze wins over increment.
  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < int'(N_EVT); i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (!freeze && evt[i]) begin
        if (&cnt_q[i]) begin
          ovf_d[i] = 1'b1;
          cnt_d[i] = (SATURATE != 0) ? cnt_q[i] : '0;
        end else begin
          cnt_d[i] = cnt_q[i] + WIDTH'(1);
        end
      end
    end
  end

  // Manual mode tracks select directly so that enabling scroll resumes from the last selection.
  always_comb begin
    div_d = '0;
    idx_d = select;
    if (auto_scroll) begin
      idx_d = idx_q;
      if (div_q == DivLast) begin
        div_d = '0;
        idx_d = (idx_q >= IdxLast) ? '0 : idx_q + SEL_W'(1);
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  // Out-of-range indices fall through to zero.
  always_comb begin
    chan_val = '0;
    if (idx_q == '0) begin
      chan_val = cap_q;
    end else begin
      for (int i = 0; i < int'(N_EVT); i++) begin
        if (idx_q == SEL_W'(i + 1)) begin
          chan_val = cnt_q[i];
        end
      end
    end
  end

  always_comb begin
    data_out_d = chan_val;
    sel_out_d  = idx_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_q      <= '0;
      ovf_q      <= '0;
      div_q      <= '0;
      idx_q      <= '0;
      data_out_q <= '0;
      sel_out_q  <= '0;
      for (int i = 0; i < int'(N_EVT); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cap_q      <= cap_d;
      ovf_q      <= ovf_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
      data_out_q <= data_out_d;
      sel_out_q  <= sel_out_d;
      for (int i = 0; i < int'(N_EVT); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign data_out = data_out_q;
  assign sel_out  = sel_out_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_perf_monitor.sv
// Randomised and directed bench for perf_monitor: wrap, saturate and wide-select instances share
// stimulus; a small integer model of counts, capture and scroll position predicts the display.
module tb_perf_monitor;

  localparam int NE = 3;
  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       capture, clear, freeze, auto_scroll;
  logic [2:0] evt;
  logic [1:0] select;
  logic [3:0] evt_x;
  logic [2:0] select_x;

  logic [7:0] data_out_w, data_out_s, data_out_x;
  logic [1:0] sel_out_w, sel_out_s;
  logic [2:0] sel_out_x;
  logic [2:0] ovf_w, ovf_s;
  logic [3:0] ovf_x;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_cw [NE];
  int m_cs [NE];
  bit [2:0] m_ow, m_os;
  int m_cap, m_idx, m_div;
  logic [7:0] e_dw, e_ds;
  logic [1:0] e_sel;

  assign evt_x = {1'b0, evt};

  always #5 clk = ~clk;

  perf_monitor #(.WIDTH(8), .N_EVT(3), .SATURATE(0), .SCROLL_DIV(4)) dut_w (
    .clk(clk), .rst(rst), .data_in(data_in), .capture(capture), .evt(evt), .clear(clear),
    .freeze(freeze), .select(select), .auto_scroll(auto_scroll), .data_out(data_out_w),
    .sel_out(sel_out_w), .ovf(ovf_w)
  );

  perf_monitor #(.WIDTH(8), .N_EVT(3), .SATURATE(1), .SCROLL_DIV(4)) dut_s (
    .clk(clk), .rst(rst), .data_in(data_in), .capture(capture), .evt(evt), .clear(clear),
    .freeze(freeze), .select(select), .auto_scroll(auto_scroll), .data_out(data_out_s),
    .sel_out(sel_out_s), .ovf(ovf_s)
  );

  perf_monitor #(.WIDTH(8), .N_EVT(4), .SATURATE(0), .SCROLL_DIV(4)) dut_x (
    .clk(clk), .rst(rst), .data_in(data_in), .capture(capture), .evt(evt_x), .clear(clear),
    .freeze(freeze), .select(select_x), .auto_scroll(auto_scroll), .data_out(data_out_x),
    .sel_out(sel_out_x), .ovf(ovf_x)
  );

  function automatic int chan(int idx, bit sat);
    if (idx == 0) return m_cap;
    if (idx <= NE) return sat ? m_cs[idx-1] : m_cw[idx-1];
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin
      m_cw[i] = 0;
      m_cs[i] = 0;
    end
    m_ow = '0; m_os = '0; m_cap = 0; m_idx = 0; m_div = 0;
    e_dw = '0; e_ds = '0; e_sel = '0;
  endtask

  // Advance the model by one edge using the inputs currently applied, then let the DUT take it.
  task automatic tick();
    e_sel = 2'(m_idx);
    e_dw  = 8'(chan(m_idx, 1'b0));
    e_ds  = 8'(chan(m_idx, 1'b1));
    if (capture) m_cap = int'(data_in);
    if (clear) begin
      for (int i = 0; i < NE; i++) begin
        m_cw[i] = 0;
        m_cs[i] = 0;
      end
      m_ow = '0;
      m_os = '0;
    end else if (!freeze) begin
      for (int i = 0; i < NE; i++) begin
        if (evt[i]) begin
          if (m_cw[i] + 1 > 255) m_ow[i] = 1'b1;
          m_cw[i] = (m_cw[i] + 1) % 256;
          if (m_cs[i] + 1 > 255) m_os[i] = 1'b1;
          else m_cs[i] = m_cs[i] + 1;
        end
      end
    end
    if (!auto_scroll) begin
      m_idx = int'(select);
      m_div = 0;
    end else begin
      m_div = m_div + 1;
      if (m_div == SD) begin
        m_div = 0;
        m_idx = (m_idx + 1) % (NE + 1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    data_in = '0; capture = 0; clear = 0; freeze = 0; auto_scroll = 0;
    evt = '0; select = '0; select_x = '0;
    model_reset();
    #3;
    total++; if (data_out_w !== 8'd0) begin bad++; $display("FAIL reset_data_w got %0h want 0", data_out_w); end
    total++; if (sel_out_w !== 2'd0) begin bad++; $display("FAIL reset_sel_w got %0d want 0", sel_out_w); end
    total++; if (ovf_w !== 3'd0) begin bad++; $display("FAIL reset_ovf_w got %0b want 0", ovf_w); end
    total++; if (data_out_s !== 8'd0) begin bad++; $display("FAIL reset_data_s got %0h want 0", data_out_s); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_count();
    select = 2'd1;
    evt = 3'b001;
    repeat (5) tick();
    evt = 3'b000;
    tick();
    total++; if (data_out_w !== 8'd5) begin bad++; $display("FAIL count5 got %0d want 5", data_out_w); end
    total++; if (sel_out_w !== 2'd1) begin bad++; $display("FAIL count_sel got %0d want 1", sel_out_w); end
    for (int c = 2; c <= 3; c++) begin
      select = 2'(c);
      tick();
      tick();
      total++;
      if (data_out_w !== 8'd0) begin
        bad++; $display("FAIL count_other ch%0d got %0d want 0", c, data_out_w);
      end
    end
  endtask

  task automatic test_overflow();
    clear = 1; tick(); clear = 0;
    select = 2'd1;
    evt = 3'b001;
    repeat (256) tick();
    evt = 3'b000;
    tick();
    total++; if (data_out_w !== 8'd0) begin bad++; $display("FAIL wrap_val got %0d want 0", data_out_w); end
    total++; if (ovf_w !== 3'b001) begin bad++; $display("FAIL wrap_ovf got %0b want 001", ovf_w); end
    total++; if (data_out_s !== 8'd255) begin bad++; $display("FAIL sat_val got %0d want 255", data_out_s); end
    total++; if (ovf_s !== 3'b001) begin bad++; $display("FAIL sat_ovf got %0b want 001", ovf_s); end
    evt = 3'b001; tick(); tick(); evt = 3'b000; tick();
    total++; if (data_out_w !== 8'd2) begin bad++; $display("FAIL wrap_after got %0d want 2", data_out_w); end
    total++; if (ovf_w !== 3'b001) begin bad++; $display("FAIL ovf_sticky got %0b want 001", ovf_w); end
    total++; if (data_out_s !== 8'd255) begin bad++; $display("FAIL sat_hold got %0d want 255", data_out_s); end
  endtask

  task automatic test_clear_freeze();
    evt = 3'b111; clear = 1; tick();
    clear = 0; evt = 3'b000; tick();
    total++; if (ovf_w !== 3'b000) begin bad++; $display("FAIL clear_ovf_w got %0b want 0", ovf_w); end
    total++; if (ovf_s !== 3'b000) begin bad++; $display("FAIL clear_ovf_s got %0b want 0", ovf_s); end
    total++; if (data_out_w !== 8'd0) begin bad++; $display("FAIL clear_val got %0d want 0", data_out_w); end
    evt = 3'b111; repeat (3) tick();
    freeze = 1; repeat (3) tick();
    freeze = 0; evt = 3'b000;
    for (int c = 1; c <= 3; c++) begin
      select = 2'(c);
      tick();
      tick();
      total++;
      if (data_out_w !== 8'd3) begin
        bad++; $display("FAIL freeze_hold ch%0d got %0d want 3", c, data_out_w);
      end
    end
  endtask

  task automatic test_capture();
    capture = 1; data_in = 8'hA5; select = 2'd0; tick();
    capture = 0; data_in = 8'(($urandom % 255) + 1); tick();
    total++; if (data_out_w !== 8'hA5) begin bad++; $display("FAIL capture got %0h want a5", data_out_w); end
    clear = 1; tick(); clear = 0; tick();
    total++; if (data_out_w !== 8'hA5) begin bad++; $display("FAIL capture_clear got %0h want a5", data_out_w); end
  endtask

  task automatic test_scroll();
    int seq [5];
    seq = '{2, 3, 0, 1, 2};
    select = 2'd2; tick(); tick();
    auto_scroll = 1;
    select = 2'd0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      total++;
      if (sel_out_w !== 2'(seq[(e-1)/4])) begin
        bad++; $display("FAIL scroll_seq edge%0d got %0d want %0d", e, sel_out_w, seq[(e-1)/4]);
      end
    end
    auto_scroll = 0;
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      data_in = 8'($urandom);
      capture = ($urandom % 4) == 0;
      evt = 3'($urandom);
      clear = ($urandom % 40) == 0;
      freeze = ($urandom % 7) == 0;
      select = 2'($urandom);
      if (($urandom % 25) == 0) auto_scroll = ~auto_scroll;
      tick();
      total++; if (data_out_w !== e_dw) begin bad++; $display("FAIL rnd_data_w n%0d got %0h want %0h", n, data_out_w, e_dw); end
      total++; if (data_out_s !== e_ds) begin bad++; $display("FAIL rnd_data_s n%0d got %0h want %0h", n, data_out_s, e_ds); end
      total++; if (sel_out_w !== e_sel) begin bad++; $display("FAIL rnd_sel n%0d got %0d want %0d", n, sel_out_w, e_sel); end
      total++; if (ovf_w !== m_ow) begin bad++; $display("FAIL rnd_ovf_w n%0d got %0b want %0b", n, ovf_w, m_ow); end
      total++; if (ovf_s !== m_os) begin bad++; $display("FAIL rnd_ovf_s n%0d got %0b want %0b", n, ovf_s, m_os); end
    end
    capture = 0; clear = 0; freeze = 0; auto_scroll = 0; evt = '0;
    tick();
  endtask

  task automatic test_reset_async();
    select = 2'd1; select_x = 3'd1; evt = 3'b111;
    repeat (6) tick();
    evt = 3'b000;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    model_reset();
    total++; if (data_out_w !== 8'd0) begin bad++; $display("FAIL async_data_w got %0h want 0", data_out_w); end
    total++; if (sel_out_w !== 2'd0) begin bad++; $display("FAIL async_sel_w got %0d want 0", sel_out_w); end
    total++; if (ovf_w !== 3'd0) begin bad++; $display("FAIL async_ovf_w got %0b want 0", ovf_w); end
    total++; if (data_out_x !== 8'd0) begin bad++; $display("FAIL async_data_x got %0h want 0", data_out_x); end
    total++; if (sel_out_x !== 3'd0) begin bad++; $display("FAIL async_sel_x got %0d want 0", sel_out_x); end
    #1 rst = 1'b0;
    select = 2'd1;
    tick();
    total++; if (data_out_w !== 8'd0) begin bad++; $display("FAIL post_rst_data got %0h want 0", data_out_w); end
    select_x = 3'd7;
    tick();
    tick();
    total++; if (sel_out_x !== 3'd7) begin bad++; $display("FAIL sel7_sel got %0d want 7", sel_out_x); end
    total++; if (data_out_x !== 8'd0) begin bad++; $display("FAIL sel7_data got %0h want 0", data_out_x); end
  endtask

  initial begin
    test_reset();
    test_count();
    test_overflow();
    test_clear_freeze();
    test_capture();
    test_scroll();
    test_random();
    test_reset_async();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/perf_monitor.md
PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the data and counter width in bits (>=2).
REQ-002 SHALL have parameter N_EVT, default 3, the number of event counters (1..15).
REQ-003 SHALL have parameter SATURATE, default 0: 0 = counters wrap, 1 = counters saturate at all-ones.
REQ-004 SHALL have parameter SCROLL_DIV, default 50000000, the clock cycles per auto-scroll step (>=1).
REQ-005 SHALL derive local SEL_W = clog2(N_EVT+1), minimum 1.
REQ-006 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 data_in  in  WIDTH  value offered to the capture register.
REQ-009 capture  in  1  load data_in into the capture register.
REQ-010 evt  in  N_EVT  per-channel count-enable, one increment per cycle high.
REQ-011 clear  in  1  synchronous clear of all counters and overflow flags.
REQ-012 freeze  in  1  hold all counters.
REQ-013 select  in  SEL_W  manual channel select: 0 = capture register, i = counter i-1.
REQ-014 auto_scroll  in  1  1 = channel index advances automatically.
REQ-015 data_out  out  WIDTH  registered value of the displayed channel.
REQ-016 sel_out  out  SEL_W  index of the channel currently in data_out.
REQ-017 ovf  out  N_EVT  sticky per-counter overflow flags.

Function
REQ-018 Capture register SHALL load data_in on each edge with capture=1, unaffected by freeze and clear.
REQ-019 Counter i SHALL increment by 1 on each edge with evt[i]=1, freeze=0, clear=0.
REQ-020 Priority per edge SHALL be clear > freeze > increment; clear zeroes every counter and every ovf bit.
REQ-021 SATURATE=0: increment at all-ones SHALL wrap counter to 0 and set ovf[i].
REQ-022 SATURATE=1: increment at all-ones SHALL hold all-ones and set ovf[i].
REQ-023 ovf[i] SHALL remain set until clear or rst, regardless of later increments.
REQ-024 auto_scroll=0: internal index SHALL equal select each cycle; scroll divider SHALL be held at 0.
REQ-025 auto_scroll=1: divider SHALL count 0..SCROLL_DIV-1; on the edge where it equals SCROLL_DIV-1 it returns to 0 and index advances by 1, wrapping N_EVT -> 0.
REQ-026 On auto_scroll rising, scrolling SHALL start from the index last taken from select.
REQ-027 select values > N_EVT in manual mode SHALL be taken as index but SHALL display 0.
REQ-028 data_out and sel_out SHALL update every edge from the pre-edge index and pre-edge channel value (1-cycle latency from counter/capture update to data_out).
REQ-029 Counter-to-display path SHALL have no combinational path from any input to any output.

Reset
REQ-030 rst=1 SHALL immediately, without clock, force all counters, capture register, ovf, divider, index, data_out and sel_out to 0.
REQ-031 rst asserted mid-scroll or mid-count SHALL discard state; after release first edge behaves as from power-on.

Verification (WIDTH=8, N_EVT=3, SCROLL_DIV=4 unless noted)
REQ-032 evt=3'b001 for 5 cycles, select=1 -> data_out=5 one cycle after the 5th edge; counters 2,3 remain 0.
REQ-033 Counter 0 driven 256 times, SATURATE=0 -> value 0, ovf=3'b001; repeat with SATURATE=1 -> value 255, ovf=3'b001.
REQ-034 evt=3'b111 with clear=1 same cycle -> all counters 0, ovf=0; freeze=1 for 3 evt cycles -> counts unchanged.
REQ-035 capture=1 with data_in=8'hA5, select=0 -> data_out=8'hA5 after two edges; later clear leaves 8'hA5.
REQ-036 select=2, auto_scroll 0->1 -> sel_out sequence 2,3,0,1,2 changing every 4 cycles.
REQ-037 rst pulsed between edges with counters nonzero -> all outputs 0 before next edge; select=7 manual -> data_out=0, sel_out=7.
